// File: rtl/register_bank_sb.sv
// Register bank with a busy-bit scoreboard, write-back bypass on the read ports,
// and a valid/ready serial dump of every register.
module register_bank_sb #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned WORD_SIZE  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [WORD_SIZE-1:0]  rs1_data,
  output logic                  rs1_busy,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [WORD_SIZE-1:0]  rs2_data,
  output logic                  rs2_busy,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [WORD_SIZE-1:0]  wb_data,
  input  logic                  dump_start,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [WORD_SIZE-1:0]  dump_data,
  output logic                  dump_done
);

  localparam int unsigned REG_COUNT = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_COUNT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [WORD_SIZE-1:0]  regs [REG_COUNT];
  logic [REG_COUNT-1:0]  busy;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] idx, idx_d;
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [WORD_SIZE-1:0]  load_data;
  logic                  done_d;

  logic rs1_hit, rs2_hit, load_hit;

  // Read ports: R0 is hard zero, then write-back bypass, then storage.
  assign rs1_hit  = wb_valid && (wb_addr == rs1_addr);
  assign rs2_hit  = wb_valid && (wb_addr == rs2_addr);
  assign load_hit = wb_valid && (wb_addr == load_addr);

  assign rs1_data = (rs1_addr == '0) ? '0 : (rs1_hit ? wb_data : regs[rs1_addr]);
  assign rs2_data = (rs2_addr == '0) ? '0 : (rs2_hit ? wb_data : regs[rs2_addr]);
  assign rs1_busy = (rs1_addr != '0) && busy[rs1_addr] && !rs1_hit;
  assign rs2_busy = (rs2_addr != '0) && busy[rs2_addr] && !rs2_hit;

  assign load_data = (load_addr == '0) ? '0 : (load_hit ? wb_data : regs[load_addr]);

  // Storage and scoreboard; a same-cycle issue overrides the write-back clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      regs[0] <= '0;
      busy[0] <= 1'b0;
      for (int unsigned i = 1; i < REG_COUNT; i++) begin
        if (wb_valid && (wb_addr == ADDR_WIDTH'(i))) regs[i] <= wb_data;
        if (issue_valid && (issue_addr == ADDR_WIDTH'(i))) busy[i] <= 1'b1;
        else if (wb_valid && (wb_addr == ADDR_WIDTH'(i))) busy[i] <= 1'b0;
      end
    end
  end

  // Dump FSM state register; dump_data only moves when a new beat is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      dump_data <= '0;
      dump_done <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      dump_done <= done_d;
      if (load_en) dump_data <= load_data;
    end
  end

  // Dump FSM next state.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    load_en   = 1'b0;
    load_addr = '0;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        if (dump_start) begin
          state_d   = SEND;
          idx_d     = '0;
          load_en   = 1'b1;
          load_addr = '0;
        end
      end
      SEND: begin
        if (dump_ready) begin
          if (idx == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx + ADDR_WIDTH'(1);
            load_en   = 1'b1;
            load_addr = idx + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dump_valid = (state == SEND);
  assign dump_addr  = idx;

endmodule

// File: tb/tb_register_bank_sb.sv
// Self-checking bench for register_bank_sb: directed vector table, hand-written
// dump sequences, then randomized traffic against a behavioural model.
module tb_register_bank_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rs1_addr, rs2_addr, issue_addr, wb_addr, dump_addr;
  logic [15:0] rs1_data, rs2_data, wb_data, dump_data;
  logic        rs1_busy, rs2_busy, issue_valid, wb_valid;
  logic        dump_start, dump_valid, dump_ready, dump_done;

  int n_cmp = 0;
  int n_err = 0;

  register_bank_sb #(.ADDR_WIDTH(4), .WORD_SIZE(16)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  // Behavioural model: register values, pending set, and the beat being offered.
  logic [15:0] m_regs [16];
  bit          m_busy [16];
  bit          m_active;
  int          m_idx;
  logic [15:0] m_ddata;
  bit          m_done;

  function automatic logic [15:0] m_read(input int a);
    if (a == 0) return 16'h0;
    if (wb_valid && int'(wb_addr) == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit m_busy_out(input int a);
    return (a != 0) && m_busy[a] && !(wb_valid && int'(wb_addr) == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 16'h0;
      m_busy[i] = 1'b0;
    end
    m_active = 1'b0;
    m_idx    = 0;
    m_ddata  = 16'h0;
    m_done   = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        if (dump_start) begin
          m_active = 1'b1;
          m_idx    = 0;
          m_ddata  = 16'h0;
        end
      end else if (dump_ready) begin
        if (m_idx == 15) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_ddata = m_read(m_idx + 1);
          m_idx++;
        end
      end
      if (wb_valid && wb_addr != 4'd0) m_regs[wb_addr] = wb_data;
      if (wb_valid) m_busy[wb_addr] = 1'b0;
      if (issue_valid && issue_addr != 4'd0) m_busy[issue_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("rs1_data", 32'(rs1_data), 32'(m_read(int'(rs1_addr))));
    chk("rs1_busy", 32'(rs1_busy), 32'(m_busy_out(int'(rs1_addr))));
    chk("rs2_data", 32'(rs2_data), 32'(m_read(int'(rs2_addr))));
    chk("rs2_busy", 32'(rs2_busy), 32'(m_busy_out(int'(rs2_addr))));
    chk("dump_valid", 32'(dump_valid), 32'(m_active));
    if (m_active) chk("dump_addr", 32'(dump_addr), 32'(m_idx));
    chk("dump_data", 32'(dump_data), 32'(m_ddata));
    chk("dump_done", 32'(dump_done), 32'(m_done));
  endtask

  task automatic idle_inputs();
    rs1_addr = 4'd0; rs2_addr = 4'd0;
    issue_valid = 1'b0; issue_addr = 4'd0;
    wb_valid = 1'b0; wb_addr = 4'd0; wb_data = 16'h0;
    dump_start = 1'b0; dump_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  rs1_addr, rs2_addr;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        issue_valid;
    logic [3:0]  issue_addr;
    logic [15:0] e_rs1_data;
    logic        e_rs1_busy;
    logic [15:0] e_rs2_data;
    logic        e_rs2_busy;
  } vec_t;

  vec_t        vec [14];
  logic [15:0] vals [16];
  logic [15:0] old_r4;

  initial begin
    vec[0]  = '{4'd3, 4'd0, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h1234, 1'b0, 16'h0000, 1'b0};
    vec[1]  = '{4'd3, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h1234, 1'b0, 16'h0000, 1'b0};
    vec[2]  = '{4'd0, 4'd3, 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h1234, 1'b0};
    vec[3]  = '{4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vec[4]  = '{4'd7, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vec[5]  = '{4'd7, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vec[6]  = '{4'd7, 4'd0, 1'b1, 4'd7, 16'h7777, 1'b1, 4'd7, 16'h7777, 1'b0, 16'h0000, 1'b0};
    vec[7]  = '{4'd7, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h7777, 1'b1, 16'h0000, 1'b0};
    vec[8]  = '{4'd7, 4'd0, 1'b1, 4'd7, 16'h0707, 1'b0, 4'd0, 16'h0707, 1'b0, 16'h0000, 1'b0};
    vec[9]  = '{4'd7, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0707, 1'b0, 16'h0000, 1'b0};
    vec[10] = '{4'd3, 4'd5, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'h1234, 1'b0, 16'hBEEF, 1'b0};
    vec[11] = '{4'd3, 4'd5, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 16'h1234, 1'b0, 16'hBEEF, 1'b0};
    vec[12] = '{4'd0, 4'd5, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'h0000, 1'b0, 16'hBEEF, 1'b1};
    vec[13] = '{4'd0, 4'd5, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 16'hBEEF, 1'b1};

    // Reset state
    idle_inputs();
    model_reset();
    rst = 1'b1;
    #2;
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_dump_done", 32'(dump_done), 32'd0);
    chk("rst_dump_data", 32'(dump_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vector table
    for (int v = 0; v < 14; v++) begin
      rs1_addr = vec[v].rs1_addr; rs2_addr = vec[v].rs2_addr;
      wb_valid = vec[v].wb_valid; wb_addr = vec[v].wb_addr; wb_data = vec[v].wb_data;
      issue_valid = vec[v].issue_valid; issue_addr = vec[v].issue_addr;
      #1;
      chk($sformatf("vec%0d_rs1_data", v), 32'(rs1_data), 32'(vec[v].e_rs1_data));
      chk($sformatf("vec%0d_rs1_busy", v), 32'(rs1_busy), 32'(vec[v].e_rs1_busy));
      chk($sformatf("vec%0d_rs2_data", v), 32'(rs2_data), 32'(vec[v].e_rs2_data));
      chk($sformatf("vec%0d_rs2_busy", v), 32'(rs2_busy), 32'(vec[v].e_rs2_busy));
      tick();
    end
    idle_inputs();

    // Full dump with dump_ready held high
    vals[0] = 16'h0;
    for (int k = 1; k < 16; k++) vals[k] = 16'(k * 16'h1111) ^ 16'h5A5A;
    for (int k = 1; k < 16; k++) begin
      wb_valid = 1'b1; wb_addr = 4'(k); wb_data = vals[k];
      tick();
    end
    idle_inputs();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    dump_ready = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      if (c <= 16) begin
        chk($sformatf("dump%0d_valid", c - 1), 32'(dump_valid), 32'd1);
        chk($sformatf("dump%0d_addr", c - 1), 32'(dump_addr), 32'(c - 1));
        chk($sformatf("dump%0d_data", c - 1), 32'(dump_data), 32'(vals[c - 1]));
        chk($sformatf("dump%0d_done", c - 1), 32'(dump_done), 32'd0);
      end else begin
        chk($sformatf("dump_c%0d_valid", c), 32'(dump_valid), 32'd0);
        chk($sformatf("dump_c%0d_done", c), 32'(dump_done), 32'(c == 17));
      end
      tick();
    end
    idle_inputs();

    // Stall at index 4 while R4 is rewritten
    old_r4 = vals[4];
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    dump_ready = 1'b1;
    repeat (4) tick();
    dump_ready = 1'b0;
    wb_valid = 1'b1; wb_addr = 4'd4; wb_data = 16'hAAAA;
    #1;
    chk("stall_addr", 32'(dump_addr), 32'd4);
    chk("stall_data_pre", 32'(dump_data), 32'(old_r4));
    tick();
    wb_valid = 1'b0;
    #1;
    chk("stall_data_hold1", 32'(dump_data), 32'(old_r4));
    tick();
    rs1_addr = 4'd4;
    #1;
    chk("stall_data_hold2", 32'(dump_data), 32'(old_r4));
    chk("stall_r4_new", 32'(rs1_data), 32'hAAAA);
    dump_ready = 1'b1;
    tick();
    chk("stall_next_addr", 32'(dump_addr), 32'd5);
    chk("stall_next_data", 32'(dump_data), 32'(vals[5]));
    for (int c = 0; c < 12; c++) begin
      check_all();
      tick();
    end
    idle_inputs();

    // Reset in the middle of a dump at index 9
    issue_valid = 1'b1; issue_addr = 4'd9;
    tick();
    issue_valid = 1'b0;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    dump_ready = 1'b1;
    repeat (9) tick();
    dump_ready = 1'b0;
    chk("mid_addr", 32'(dump_addr), 32'd9);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_valid", 32'(dump_valid), 32'd0);
    chk("mid_rst_done", 32'(dump_done), 32'd0);
    chk("mid_rst_data", 32'(dump_data), 32'd0);
    for (int a = 0; a < 16; a++) begin
      rs1_addr = 4'(a); rs2_addr = 4'(15 - a);
      #1;
      chk($sformatf("mid_rst_r%0d", a), 32'(rs1_data), 32'd0);
      chk($sformatf("mid_rst_b%0d", a), 32'(rs1_busy), 32'd0);
      chk($sformatf("mid_rst_r2_%0d", 15 - a), 32'(rs2_data), 32'd0);
      chk($sformatf("mid_rst_b2_%0d", 15 - a), 32'(rs2_busy), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("post_rst_done", 32'(dump_done), 32'd0);
      check_all();
      tick();
    end

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      rs1_addr    = 4'($urandom_range(0, 15));
      rs2_addr    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : wb_addr;
      wb_valid    = 1'($urandom_range(0, 1));
      wb_addr     = 4'($urandom_range(0, 15));
      wb_data     = 16'($urandom);
      issue_valid = ($urandom_range(0, 9) < 3);
      issue_addr  = 4'($urandom_range(0, 15));
      dump_start  = ($urandom_range(0, 19) == 0);
      dump_ready  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) rs1_addr = wb_addr;
      #1;
      check_all();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_bank_sb.md
REGISTER_BANK_SB -- requirements
Module: register_bank_sb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: register index width; REG_COUNT = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter WORD_SIZE, default 16: register data width.
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- rs1_addr  in  ADDR_WIDTH  read port 1 index.
- rs1_data  out  WORD_SIZE  read port 1 data.
- rs1_busy  out  1  read port 1 operand pending.
- rs2_addr  in  ADDR_WIDTH  read port 2 index.
- rs2_data  out  WORD_SIZE  read port 2 data.
- rs2_busy  out  1  read port 2 operand pending.
- issue_valid  in  1  mark the issue_addr register pending.
- issue_addr  in  ADDR_WIDTH  destination of the issued instruction.
- wb_valid  in  1  write-back strobe.
- wb_addr  in  ADDR_WIDTH  write-back index.
- wb_data  in  WORD_SIZE  write-back data.
- dump_start  in  1  request a serial dump of all registers.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  dump beat accepted.
- dump_addr  out  ADDR_WIDTH  index of the current beat.
- dump_data  out  WORD_SIZE  value of the current beat.
- dump_done  out  1  one-cycle pulse after the last beat.

Function
REQ-005 SHALL hold REG_COUNT registers of WORD_SIZE bits; R0 SHALL always read 0, SHALL never be written and SHALL never be busy.
REQ-006 SHALL write wb_data into reg[wb_addr] at the rising edge when wb_valid=1 and wb_addr!=0.
REQ-007 SHALL provide combinational read ports with the following priority: addr==0 gives 0; otherwise addr==wb_addr with wb_valid=1 gives wb_data (bypass); otherwise the data is the stored value.
REQ-008 SHALL keep a busy bit per register: issue_valid with issue_addr!=0 sets the bit at the clock edge; wb_valid clears busy[wb_addr] at the clock edge.
REQ-009 SHALL leave the busy bit set when issue and write-back target the same register in one cycle (issue wins; a new producer is pending).
REQ-010 SHALL compute rsN_busy = busy[rsN_addr] AND NOT (wb_valid AND wb_addr==rsN_addr); it SHALL be 0 for addr 0.
REQ-011 SHALL implement the dump FSM with states IDLE and SEND.
- IDLE with dump_start=1: go to SEND, index=0.
- dump_start in SEND: ignored.
REQ-012 SHALL drive dump_valid=1 in SEND only, with dump_addr equal to the current index.
REQ-013 SHALL register dump_data and update it only on entry to SEND or on a handshake, loading the value of the next index.
- The loaded value SHALL use the REQ-007 bypass.
- dump_data SHALL stay stable while dump_valid=1 and dump_ready=0, even if that register is written.
REQ-014 SHALL treat a handshake (dump_valid AND dump_ready) as follows:
- index < REG_COUNT-1: the index increments.
- index = REG_COUNT-1: go to IDLE and assert dump_done for exactly the next cycle.
REQ-015 SHALL not allow the dump to stall, alter or be altered by the scoreboard or the read ports.
REQ-016 SHALL have a dump latency of 1 cycle from dump_start to dump_valid; back-to-back handshakes SHALL yield one beat per cycle.

Reset
REQ-017 SHALL, on rst=1 and asynchronously, clear all registers to 0 and all busy bits to 0, put the FSM in IDLE with index 0, and drive dump_valid=0, dump_done=0, dump_data=0.
REQ-018 SHALL abandon a dump in progress on reset without asserting dump_done; normal operation SHALL resume at the first clock edge after rst falls.

Verification
REQ-019 SHALL cover: write R3=0x1234, then read rs1_addr=3 -> rs1_data=0x1234; wb_valid to R0 with 0xFFFF -> R0 reads 0.
REQ-020 SHALL cover: wb_valid, wb_addr=5, wb_data=0xBEEF with rs2_addr=5 in the same cycle -> rs2_data=0xBEEF combinationally, rs2_busy=0.
REQ-021 SHALL cover: issue R7 -> rs1_busy=1 on the next cycle; issue R7 and write back R7 in the same cycle -> R7 stays busy; write back alone -> busy clears.
REQ-022 SHALL cover: dump with dump_ready held at 1 -> 16 beats with addr 0..15 carrying the written values, then dump_done pulses once, 17 cycles after start.
REQ-023 SHALL cover: dump with dump_ready=0 at index 4 while R4 is rewritten to 0xAAAA -> dump_data holds the old value until the handshake.
REQ-024 SHALL cover: rst asserted mid-dump at index 9 -> dump_valid=0 immediately, no dump_done, all reads 0, all busy bits 0.
